// File: rtl/clock_divider_ctrl.sv
// Run-time controller for an even clock divider. Ratio changes and stops take
// effect only at a period boundary, so clk_div_o never produces a short pulse.
module clock_divider_ctrl #(
  parameter int TCQ        = 1,
  parameter int C_DIV_W    = 8,
  parameter int C_DIV_INIT = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [C_DIV_W-1:0] cfg_div_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  output logic               cfg_err_o,
  output logic               clk_div_o,
  output logic               tick_o,
  output logic               busy_o,
  output logic [C_DIV_W-1:0] div_cur_o
);

  localparam int                 CW      = C_DIV_W - 1;
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [C_DIV_W-1:0] DIV_RST = C_DIV_W'(C_DIV_INIT);

  // Elaboration-only hook for illegal parameter sets; holds no logic.
  if (TCQ < 0 || C_DIV_INIT < 2 || (C_DIV_INIT % 2) != 0) begin : g_bad_param
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic               r_clk_div, r_tick, r_err;
  logic [C_DIV_W-1:0] r_div_cur, r_pend_div;
  logic               r_pend_vld;

  logic [CW-1:0] w_half;
  logic          w_run, w_hit, w_bnd, w_xfer, w_legal;

  assign w_half  = r_div_cur[C_DIV_W-1:1];
  assign w_run   = (r_state != S_IDLE);
  assign w_hit   = (r_cnt == (w_half - CNT_ONE));
  // Boundary: end of the high phase, next edge is high->low.
  assign w_bnd   = w_run && w_hit && r_clk_div;
  assign w_xfer  = cfg_valid_i && cfg_ready_o;
  assign w_legal = !cfg_div_i[0] && (|cfg_div_i[C_DIV_W-1:1]);

  assign cfg_ready_o = (r_state == S_IDLE) || (r_state == S_RUN && !r_pend_vld);
  assign cfg_err_o   = r_err;
  assign clk_div_o   = r_clk_div;
  assign tick_o      = r_tick;
  assign busy_o      = w_run;
  assign div_cur_o   = r_div_cur;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en_i) w_state_nxt = S_RUN;
      S_RUN:   if (!en_i) w_state_nxt = S_STOP;
      S_STOP: begin
        if (en_i)       w_state_nxt = S_RUN;
        else if (w_bnd) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_clk_div <= 1'b0;
      r_tick    <= 1'b0;
    end else if (!w_run) begin
      r_cnt     <= '0;
      r_clk_div <= 1'b0;
      r_tick    <= 1'b0;
    end else if (w_hit) begin
      r_cnt     <= '0;
      r_clk_div <= ~r_clk_div;
      r_tick    <= ~r_clk_div;
    end else begin
      r_cnt     <= r_cnt + CNT_ONE;
      r_tick    <= 1'b0;
    end
  end

  // Pending ratio can only be loaded while none is held, so a boundary apply
  // and a new load never collide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_div_cur  <= DIV_RST;
      r_pend_div <= '0;
      r_pend_vld <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_xfer && !w_legal;
      if (w_bnd && r_pend_vld) begin
        r_div_cur  <= r_pend_div;
        r_pend_vld <= 1'b0;
      end
      if (w_xfer && w_legal) begin
        if (r_state == S_IDLE) r_div_cur <= cfg_div_i;
        else begin
          r_pend_div <= cfg_div_i;
          r_pend_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Bench for clock_divider_ctrl: legality table, directed period sequences and
// randomized traffic checked every cycle against a period-position model.
module tb_clock_divider_ctrl;

  logic       clk, rst_n, en, valid;
  logic [7:0] cfg_div;
  logic       ready, err, clk_div, tick, busy;
  logic [7:0] div_cur;

  int n_chk = 0;
  int n_pass = 0;

  clock_divider_ctrl #(.TCQ(1), .C_DIV_W(8), .C_DIV_INIT(10)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .cfg_div_i(cfg_div),
    .cfg_valid_i(valid), .cfg_ready_o(ready), .cfg_err_o(err),
    .clk_div_o(clk_div), .tick_o(tick), .busy_o(busy), .div_cur_o(div_cur)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: mode 0 idle / 1 run / 2 stop, pos = cycle index inside the period.
  int m_mode, m_div, m_pos, m_pdiv;
  bit m_pvld, m_err;

  always @(posedge clk or negedge rst_n) begin : model
    bit b, rdy, xfer, legal, bnd;
    int nmode;
    if (!rst_n) begin
      m_mode = 0; m_div = 10; m_pos = 0; m_pvld = 0; m_pdiv = 0; m_err = 0;
    end else begin
      b     = (m_mode != 0);
      rdy   = (m_mode == 0) || (m_mode == 1 && !m_pvld);
      xfer  = valid && rdy;
      legal = (cfg_div % 2 == 0) && (cfg_div >= 2);
      bnd   = b && (m_pos == m_div - 1);
      m_err = xfer && !legal;
      m_pos = b ? (bnd ? 0 : m_pos + 1) : 0;
      if (bnd && m_pvld) begin m_div = m_pdiv; m_pvld = 0; end
      if (xfer && legal) begin
        if (m_mode == 0) m_div = int'(cfg_div);
        else begin m_pdiv = int'(cfg_div); m_pvld = 1; end
      end
      case (m_mode)
        0:       nmode = en ? 1 : 0;
        1:       nmode = en ? 1 : 2;
        default: nmode = en ? 1 : (bnd ? 0 : 2);
      endcase
      m_mode = nmode;
      if (m_mode == 0) m_pos = 0;
    end
  end

  function automatic logic [12:0] m_exp();
    bit b;
    b = (m_mode != 0);
    return {b && (m_pos >= m_div / 2), b && (m_pos == m_div / 2), b,
            (m_mode == 0) || (m_mode == 1 && !m_pvld), m_err, m_div[7:0]};
  endfunction

  always @(negedge clk)
    if (rst_n) chk("model", {19'd0, clk_div, tick, busy, ready, err, div_cur}, {19'd0, m_exp()});

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    do begin nxt(); n++; end while (!tick && n < maxc);
    if (!tick) chk("tick_wait", tick, 1);
  endtask

  typedef struct {
    logic [7:0] div;
    logic       err;
    logic [7:0] cur;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int n;
    tbl[0] = '{8'd4,   1'b0, 8'd4};
    tbl[1] = '{8'd7,   1'b1, 8'd4};
    tbl[2] = '{8'd0,   1'b1, 8'd4};
    tbl[3] = '{8'd1,   1'b1, 8'd4};
    tbl[4] = '{8'd2,   1'b0, 8'd2};
    tbl[5] = '{8'd255, 1'b1, 8'd2};
    tbl[6] = '{8'd254, 1'b0, 8'd254};
    tbl[7] = '{8'd10,  1'b0, 8'd10};

    rst_n = 1; en = 0; valid = 0; cfg_div = 0;
    #1 rst_n = 0;
    nxt(); nxt();
    chk("rst_clk", clk_div, 0); chk("rst_tick", tick, 0); chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 1); chk("rst_err", err, 0); chk("rst_div", div_cur, 10);
    rst_n = 1;
    nxt();

    // Legality table, applied while idle
    for (int i = 0; i < 8; i++) begin
      valid = 1; cfg_div = tbl[i].div;
      nxt();
      valid = 0;
      chk("tbl_err", err, tbl[i].err);
      chk("tbl_div", div_cur, tbl[i].cur);
    end

    // Ratio 10 from reset value: 5 low, 5 high, tick on rise
    en = 1;
    for (int k = 0; k < 30; k++) begin
      nxt();
      chk("p10_clk", clk_div, (k % 10) >= 5);
      chk("p10_tick", tick, (k % 10) == 5);
      chk("p10_busy", busy, 1);
    end

    // Illegal ratios while running are dropped
    valid = 1; cfg_div = 7;
    nxt(); chk("err7", err, 1);
    cfg_div = 0;
    nxt(); chk("err0", err, 1);
    valid = 0;
    nxt(); chk("err_clr", err, 0); chk("err_div", div_cur, 10);
    wait_tick(20, n); wait_tick(20, n); chk("err_period", n, 10);

    // Write 4 in the high phase: current period finishes at 10
    valid = 1; cfg_div = 4;
    nxt(); valid = 0; chk("pend_ready", ready, 0);
    wait_tick(20, n); chk("switch_gap", n, 6); chk("div4", div_cur, 4);
    wait_tick(20, n); chk("p4_a", n, 4);
    wait_tick(20, n); chk("p4_b", n, 4);

    // Back to 10, then stop at pos 2 of the low phase
    valid = 1; cfg_div = 10;
    nxt(); valid = 0;
    wait_tick(20, n); wait_tick(20, n); chk("p10_back", n, 10);
    for (int k = 0; k < 7; k++) nxt();
    en = 0;
    wait_tick(20, n); chk("stop_tick", n, 3); chk("stop_busy", busy, 1);
    n = 0;
    do begin nxt(); n++; end while (busy && n < 20);
    chk("stop_len", n, 5); chk("stop_clk", clk_div, 0); chk("stop_idle", busy, 0);

    // Restart, then re-enable while stopping
    en = 1;
    wait_tick(20, n); chk("first_rise", n, 6);
    for (int k = 0; k < 7; k++) nxt();
    en = 0;
    nxt(); chk("stop2_busy", busy, 1);
    en = 1;
    wait_tick(20, n); chk("resume_tick", n, 2);
    wait_tick(20, n); chk("resume_period", n, 10);

    // Ratio 2: toggle every cycle
    valid = 1; cfg_div = 2;
    nxt(); valid = 0;
    wait_tick(20, n); wait_tick(20, n); wait_tick(20, n); chk("p2", n, 2);
    chk("div2", div_cur, 2);
    for (int k = 1; k <= 6; k++) begin
      nxt();
      chk("p2_clk", clk_div, (k % 2) == 0);
      chk("p2_tick", tick, (k % 2) == 0);
    end

    // Async reset while high with a ratio pending
    nxt();
    valid = 1; cfg_div = 6;
    nxt(); valid = 0;
    chk("pre_rst_clk", clk_div, 1);
    rst_n = 0; en = 0;
    #1;
    chk("arst_clk", clk_div, 0); chk("arst_div", div_cur, 10);
    chk("arst_busy", busy, 0); chk("arst_ready", ready, 1); chk("arst_tick", tick, 0);
    nxt();
    rst_n = 1;
    nxt();
    en = 1;
    wait_tick(20, n); chk("post_rst_rise", n, 6);
    wait_tick(20, n); chk("post_rst_period", n, 10);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      nxt();
      if ($urandom_range(0, 15) == 0) en = ~en;
      valid   = ($urandom_range(0, 3) == 0);
      cfg_div = 8'($urandom_range(0, 12));
    end
    valid = 0;
    nxt(); nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
